// File: rtl/io_uart_rx.sv
// ============================================================================
//  io_uart_rx : memory-mapped 8N1 UART receiver with a small byte FIFO
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module io_uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [31:0] addr,
  input  logic        isLoad,
  output logic [31:0] rdata,
  output logic        rxValid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      C_ADDR_RXDATA = 32'h0040_0100;
  localparam logic [31:0]      C_ADDR_RXSTAT = 32'h0040_0104;
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] C_FULL_XOR = {1'b1, {(PTR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       sync_q, sync_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic             overflow_q, overflow_d;
  logic             framing_err_q, framing_err_d;

  logic             rx_s;
  logic             push_req;
  logic             frame_err;
  logic             push_ok;
  logic             pop;
  logic             empty;
  logic             full;
  logic             sel_data;
  logic             sel_stat;
  logic [7:0]       head_byte;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == C_CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack for the next start.
        if (cnt_q == C_CNT_LAST) begin
          cnt_d     = '0;
          state_d   = S_IDLE;
          push_req  = rx_s;
          frame_err = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == C_FULL_XOR);
  assign rxValid  = !empty;
  assign sel_data = (addr == C_ADDR_RXDATA);
  assign sel_stat = (addr == C_ADDR_RXSTAT);
  assign pop      = isLoad && sel_data && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = push_req && (!full || pop);
  assign head_byte = empty ? 8'h00 : mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = shift_q;
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
  end

  // Status clear on RXSTAT load; a new error on the same edge wins.
  always_comb begin
    overflow_d    = overflow_q;
    framing_err_d = framing_err_q;
    if (isLoad && sel_stat) begin
      overflow_d    = 1'b0;
      framing_err_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end
    if (frame_err) begin
      framing_err_d = 1'b1;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel_data) begin
      rdata = {23'b0, rxValid, head_byte};
    end else if (sel_stat) begin
      rdata = {28'b0, full, overflow_q, framing_err_q, rxValid};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      sync_q        <= 2'b11;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      sync_q        <= sync_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
      mem_q         <= mem_d;
    end
  end

endmodule

`default_nettype wire
